// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl
//   Channel-scan sequencer that drives the 4-bit input of a 4-to-16 one-hot
//   decoder. It walks a channel index through [first_ch..last_ch] and wraps
//   modulo 16. Each channel is held for dwell+1 cycles. A scan runs once
//   (single-shot) or repeats until stopped (continuous).
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start, stop   level controls, sampled every clk (stop has priority)
//   mode_cont     1 = continuous, 0 = single pass (latched at start)
//   first_ch      first channel of the range (latched at start)
//   last_ch       last channel of the range (latched at start)
//   dwell         hold time minus one (latched at start)
//   sel[0:3]      current channel, sel[0] = LSB
//   sel_valid     sel is a live channel
//   busy          scan in progress
//   ch_strobe     first cycle of each channel dwell
//   done          one-cycle pulse on normal single-shot completion
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic [3:0]         first_ch,
  input  logic [3:0]         last_ch,
  input  logic [DWELL_W-1:0] dwell,
  output logic [0:3]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               ch_strobe,
  output logic               done
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t               state_q, state_d;
  logic [3:0]           sel_q, sel_d;
  logic                 vld_q, vld_d;
  logic                 busy_q, busy_d;
  logic                 strb_q, strb_d;
  logic                 done_q, done_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [3:0]           first_q, first_d;
  logic [3:0]           last_q, last_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 mode_q, mode_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      strb_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      strb_q  <= strb_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    strb_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;

    unique case (state_q)
      IDLE: begin
        // start and stop together: stop wins, nothing moves
        if (start && !stop) begin
          first_d = first_ch;
          last_d  = last_ch;
          dwell_d = dwell;
          mode_d  = mode_cont;
          sel_d   = first_ch;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
          strb_d  = 1'b1;
          cnt_d   = '0;
          state_d = DWELL;
        end
      end
      DWELL: begin
        if (stop) begin
          // abort: no done pulse
          state_d = IDLE;
          sel_d   = '0;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + 1'b1;
        end else if (sel_q != last_q) begin
          sel_d  = sel_q + 4'd1;   // 4-bit add wraps 15 -> 0
          cnt_d  = '0;
          strb_d = 1'b1;
        end else if (mode_q) begin
          sel_d  = first_q;
          cnt_d  = '0;
          strb_d = 1'b1;
        end else begin
          state_d = IDLE;
          sel_d   = '0;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output is declared [0:3] with sel[0] as the LSB, so map bit-by-bit.
  assign sel       = {sel_q[0], sel_q[1], sel_q[2], sel_q[3]};
  assign sel_valid = vld_q;
  assign busy      = busy_q;
  assign ch_strobe = strb_q;
  assign done      = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, mode_cont;
  logic [3:0]    first_ch, last_ch;
  logic [DW-1:0] dwell;
  logic [0:3]    sel;
  logic          sel_valid, busy, ch_strobe, done;
  logic [3:0]    sel_n;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  decoder_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
    .first_ch(first_ch), .last_ch(last_ch), .dwell(dwell),
    .sel(sel), .sel_valid(sel_valid), .busy(busy),
    .ch_strobe(ch_strobe), .done(done)
  );

  always #5 clk = ~clk;

  assign sel_n = {sel[3], sel[2], sel[1], sel[0]};

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A scan is described by its elapsed cycle count t since acceptance:
  // channel = first + (t / (dwell+1)) mod n, strobe when t is a multiple
  // of dwell+1, single-shot ends when t reaches n*(dwell+1).
  bit m_act;
  int m_t, m_first, m_n, m_d;
  bit m_mode;
  int e_sel;
  bit e_vld, e_busy, e_strb, e_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_t = 0; m_first = 0; m_n = 1; m_d = 0; m_mode = 0;
      e_sel = 0; e_vld = 0; e_busy = 0; e_strb = 0; e_done = 0;
    end else begin
      e_done = 0;
      if (!m_act) begin
        if (start && !stop) begin
          m_first = int'(first_ch);
          m_n     = ((int'(last_ch) - int'(first_ch)) & 15) + 1;
          m_d     = int'(dwell);
          m_mode  = mode_cont;
          m_t     = 0;
          m_act   = 1;
        end
      end else if (stop) begin
        m_act = 0;
      end else begin
        m_t++;
        if (!m_mode && m_t == m_n * (m_d + 1)) begin
          m_act  = 0;
          e_done = 1;
        end
      end
      if (m_act) begin
        e_sel  = (m_first + (m_t / (m_d + 1)) % m_n) % 16;
        e_strb = (m_t % (m_d + 1)) == 0;
        e_vld  = 1; e_busy = 1;
      end else begin
        e_sel = 0; e_strb = 0; e_vld = 0; e_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("model_cycle",
          int'({sel_n, sel_valid, busy, ch_strobe, done}),
          int'({e_sel[3:0], e_vld, e_busy, e_strb, e_done}));
    end
  end

  // ---------------- directed stimulus ----------------
  int q_hist[$];
  int strb_cnt, done_cnt, done_at;
  bit busy_at_done;
  int pat[4];

  task automatic drive_start(input int f, input int l, input int d, input bit m,
                             input bit keep);
    @(negedge clk);
    first_ch = 4'(f); last_ch = 4'(l); dwell = DW'(d); mode_cont = m;
    start = 1'b1;
    @(negedge clk);
    if (!keep) start = 1'b0;
  endtask

  // Sample from the current negedge; stops on done or after max cycles.
  task automatic collect(input int max);
    q_hist.delete();
    strb_cnt = 0; done_cnt = 0; done_at = -1; busy_at_done = 1'b1;
    for (int c = 0; c < max; c++) begin
      if (sel_valid) q_hist.push_back(int'(sel_n));
      if (ch_strobe) strb_cnt++;
      if (done) begin
        done_cnt++; done_at = c; busy_at_done = busy;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_basic(input string tag);
    chk({tag, "_len"}, q_hist.size(), 12);
    for (int i = 0; i < q_hist.size() && i < 12; i++)
      chk({tag, "_sel"}, q_hist[i], 2 + i / 3);
    chk({tag, "_strobes"}, strb_cnt, 4);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_at"}, done_at, 12);
    chk({tag, "_busy_at_done"}, int'(busy_at_done), 0);
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; mode_cont = 0;
    first_ch = 0; last_ch = 0; dwell = 0;
    pat[0] = 3; pat[1] = 3; pat[2] = 4; pat[3] = 4;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({sel_n, sel_valid, busy, ch_strobe, done}), 0);
    rst = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);

    // single-shot basic
    drive_start(2, 5, 2, 0, 0);
    collect(20);
    chk_basic("basic");

    // wrap range, dwell 0
    drive_start(14, 1, 0, 0, 0);
    collect(10);
    chk("wrap_len", q_hist.size(), 4);
    if (q_hist.size() == 4) begin
      chk("wrap_s0", q_hist[0], 14); chk("wrap_s1", q_hist[1], 15);
      chk("wrap_s2", q_hist[2], 0);  chk("wrap_s3", q_hist[3], 1);
    end
    chk("wrap_strobes", strb_cnt, 4);
    chk("wrap_done_at", done_at, 4);

    // continuous mode then stop
    drive_start(3, 4, 1, 1, 0);
    collect(20);
    chk("cont_len", q_hist.size(), 20);
    for (int i = 0; i < q_hist.size(); i++) chk("cont_sel", q_hist[i], pat[i % 4]);
    chk("cont_no_done", done_cnt, 0);
    chk("cont_busy", int'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_outputs", int'({sel_n, sel_valid, busy, done}), 0);

    // start and stop together in idle
    @(negedge clk);
    first_ch = 4'd6; last_ch = 4'd8; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("startstop_idle", int'({busy, sel_valid}), 0);

    // start held and config scrambled mid-scan; start in done cycle ignored
    drive_start(2, 5, 2, 0, 1);
    first_ch = 4'd9; last_ch = 4'd10; dwell = '0; mode_cont = 1'b1;
    collect(20);
    chk_basic("midscan");
    chk("done_cycle_sel_valid", int'(sel_valid), 0);
    @(negedge clk);
    chk("restart_busy", int'(busy), 1);
    chk("restart_sel", int'(sel_n), 9);
    start = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // single channel, maximum dwell
    drive_start(7, 7, 255, 0, 0);
    collect(300);
    chk("maxdw_len", q_hist.size(), 256);
    chk("maxdw_strobes", strb_cnt, 1);
    chk("maxdw_done_at", done_at, 256);

    // async reset mid-scan
    drive_start(2, 5, 2, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", int'({sel_n, sel_valid, busy, ch_strobe, done}), 0);
    @(negedge clk);
    rst = 1'b0;
    drive_start(4, 6, 0, 0, 0);
    chk("post_rst_sel", int'(sel_n), 4);
    collect(10);
    chk("post_rst_len", q_hist.size(), 3);
    chk("post_rst_done", done_cnt, 1);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Channel-scan sequencer directly upstream of the 4-to-16 one-hot decoder; its sel output drives the decoder's 4-bit input.
- Steps a channel index through a programmable range [first_ch..last_ch] with wrap-around.
- Each channel is held for a programmable dwell time, in single-shot or continuous mode.
- Provides start/stop control, a per-channel strobe, and a scan-complete pulse.

Parameters:
- DWELL_W, 8, width of dwell counter and dwell input; cycles per channel = dwell+1 (1..2^DWELL_W).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  level sampled each clk; starts a scan when idle
- stop  input  1  level sampled each clk; aborts an active scan
- mode_cont  input  1  1 = continuous (wrap to first_ch after last_ch), 0 = single pass
- first_ch  input  4  first channel of range, unsigned 0..15
- last_ch  input  4  last channel of range, unsigned 0..15
- dwell  input  DWELL_W  channel hold time minus one
- sel  output  [0:3]  current channel code; sel[0] = LSB, sel[3] = MSB; feeds the decoder input
- sel_valid  output  1  high while sel is a live channel
- busy  output  1  high while scanning
- ch_strobe  output  1  one-cycle pulse in the first cycle of every channel dwell
- done  output  1  one-cycle pulse when a single-shot scan completes normally

Behaviour:
- Reset (async, rst=1): state=IDLE; sel=0; sel_valid=0; busy=0; ch_strobe=0; done=0; dwell counter=0; latched config=0.
- States: IDLE, DWELL.
- All outputs are registered.
- ch_strobe and done default to 0 every cycle unless set below.
- IDLE:
  - start=1 and stop=0: latch first_ch, last_ch, dwell, mode_cont.
  - Next cycle: sel=first_ch, sel_valid=1, busy=1, ch_strobe=1, cnt=0, state=DWELL.
  - Latency from start sample to valid sel: 1 cycle.
  - start=1 and stop=1 together: stop wins, remain IDLE, no outputs change.
- DWELL, evaluated in priority order:
  1. stop=1: next cycle state=IDLE, sel=0, sel_valid=0, busy=0; done stays 0 (abort is not completion).
  2. cnt != dwell_l: cnt=cnt+1, sel held.
  3. cnt == dwell_l and sel != last_l: sel=sel+1 modulo 16 (15 wraps to 0), cnt=0, ch_strobe=1.
  4. cnt == dwell_l, sel == last_l, mode_l=1: sel=first_l, cnt=0, ch_strobe=1; scan continues indefinitely.
  5. cnt == dwell_l, sel == last_l, mode_l=0: state=IDLE, sel=0, sel_valid=0, busy=0, done=1 for one cycle.
- Range rules:
  - first_ch == last_ch: single-channel scan.
  - first_ch > last_ch: scan crosses the wrap (e.g. 14,15,0,1).
  - Channels per pass = ((last-first) mod 16) + 1.
- Config latched only at start; input changes during DWELL are ignored.
- start while busy is ignored.
- dwell=0: sel changes every cycle; ch_strobe is high every cycle.
- Single-shot completion: done is asserted in the same cycle that busy falls. A start in that cycle is ignored, because the FSM is still in DWELL when start is sampled. A new start is accepted from the following cycle.
- rst asserted mid-scan: all outputs clear immediately (asynchronous), with no done pulse. The first start after rst deasserts begins a fresh scan.
- sel is never X after reset.
- sel changes only on ch_strobe cycles or on entry to IDLE.

Test Plan:
- Reset mid-scan: rst high during DWELL -> sel, sel_valid, busy, ch_strobe and done all 0 before the next clk edge; start after rst deasserts -> sel=first_ch after 1 cycle.
- Single-shot basic: first=2, last=5, dwell=2, mode=0, start pulse -> sel=2,3,4,5, each for 3 cycles; ch_strobe on 4 cycles; done=1 exactly once, 12 cycles after sel first valid; busy falls with done.
- Wrap range: first=14, last=1, dwell=0, mode=0 -> sel sequence 14,15,0,1 on consecutive cycles, ch_strobe high all 4 cycles, then done.
- Continuous mode: first=3, last=4, dwell=1, mode=1, run 20 cycles -> sel pattern 3,3,4,4 repeating, busy stays 1, no done; stop=1 -> next cycle sel=0, sel_valid=0, busy=0, done=0.
- Priority and ignoring:
  - start+stop together in IDLE -> stays IDLE.
  - start during scan, and first/last/dwell changed mid-scan -> sequence unchanged.
  - start in the done cycle -> ignored; start the next cycle -> accepted.
- Single channel and max dwell: first=last=7, dwell=255 (DWELL_W=8), mode=0 -> sel=7 for exactly 256 cycles, one ch_strobe, then done.
